// File: rtl/lut_stream_loader.sv
//------------------------------------------------------------------------------
// lut_stream_loader
//
// Streams LUT_SIZE paired entries (log2 / exp2) from a host valid/ready port
// into a LUT consumer that has no backpressure.  Each accepted beat becomes a
// single-cycle lut_wr_en pulse one cycle later, with the data registered.
//
// A load starts with a one-cycle start pulse in IDLE.  It ends in one of two
// ways:
//   DONE  after LUT_SIZE beats have been accepted.
//   ERR   after TIMEOUT_CYC consecutive cycles pass without a beat.
// Both DONE and ERR are sticky.  Only abort (which returns to IDLE) or reset
// leaves them.
//
// Compile-time option:
//   LUT_LOADER_CHECKSUM_EN  adds the lut_checksum output.  It holds the
//                           modulo-2^16 sum of every accepted log2 + exp2
//                           pair, and is cleared on start.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start               single-cycle load request (honoured in IDLE only)
//   abort               cancel a load / clear DONE or ERR, back to IDLE
//   cfg_valid/ready     host beat handshake
//   cfg_log2_data       log2 entry from the host   (MANT_LEN bits)
//   cfg_exp2_data       exp2 entry from the host   (FLOAT_LEN bits)
//   lut_wr_en           write strobe to the LUT consumer
//   log2_lut_data_out   registered log2 write data
//   exp2_lut_data_out   registered exp2 write data
//   wr_count            entries accepted in the current load
//   lut_busy/done/err   state flags for LOAD / DONE / ERR
//   lut_checksum        running checksum (LUT_LOADER_CHECKSUM_EN only)
//------------------------------------------------------------------------------
module lut_stream_loader #(
   parameter int LUT_SIZE    = 128,
   parameter int MANT_LEN    = 10,
   parameter int FLOAT_LEN   = 16,
   parameter int TIMEOUT_CYC = 1024
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        start,
   input  logic                        abort,
   input  logic                        cfg_valid,
   output logic                        cfg_ready,
   input  logic [MANT_LEN-1:0]         cfg_log2_data,
   input  logic [FLOAT_LEN-1:0]        cfg_exp2_data,
   output logic                        lut_wr_en,
   output logic [MANT_LEN-1:0]         log2_lut_data_out,
   output logic [FLOAT_LEN-1:0]        exp2_lut_data_out,
   output logic [$clog2(LUT_SIZE):0]   wr_count,
   output logic                        lut_busy,
   output logic                        lut_done,
   output logic                        lut_err
`ifdef LUT_LOADER_CHECKSUM_EN
   ,
   output logic [15:0]                 lut_checksum
`endif
);

   localparam int CW = $clog2(LUT_SIZE) + 1;
   localparam int GW = $clog2(TIMEOUT_CYC + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      DONE = 2'd2,
      ERR  = 2'd3
   } state_t;

   state_t        state;
   state_t        state_nxt;
   logic [GW-1:0] gap;
   logic          hs;
   logic          last_beat;
   logic          gap_expired;
   logic          load_begin;

   // Abort masks ready in the same cycle, so a beat offered together with
   // abort is never accepted.
   assign cfg_ready   = (state == LOAD) && !abort;
   assign hs          = cfg_valid && cfg_ready;
   assign last_beat   = (wr_count == CW'(LUT_SIZE - 1));
   // This is the idle cycle that makes the gap counter reach TIMEOUT_CYC.
   assign gap_expired = (gap == GW'(TIMEOUT_CYC - 1));
   assign load_begin  = (state == IDLE) && start && !abort;

   assign lut_busy = (state == LOAD);
   assign lut_done = (state == DONE);
   assign lut_err  = (state == ERR);

   //---------------------------------------------------------------------------
   // State register
   //---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         // NOTE: sequential state uses non-blocking assignments, so every
         // flop samples the pre-edge values regardless of block order.
         state <= state_nxt;
      end
   end

   //---------------------------------------------------------------------------
   // Next-state logic
   //---------------------------------------------------------------------------
   always_comb begin
      // NOTE: the default comes first, so no path leaves state_nxt unassigned
      // and no latch is inferred.
      state_nxt = state;
      unique case (state)
         IDLE: if (start) state_nxt = LOAD;
         LOAD: begin
            if (hs && last_beat)
               state_nxt = DONE;
            else if (!hs && gap_expired)
               state_nxt = ERR;
         end
         default: ;  // DONE and ERR hold until abort
      endcase
      // Abort overrides everything, including a start seen in IDLE.
      if (abort) state_nxt = IDLE;
   end

   //---------------------------------------------------------------------------
   // Datapath: write strobe, output data, beat and gap counters
   //---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: every datapath register has an async reset.  A reset in the
         // middle of a beat therefore drops the pending strobe at once.
         lut_wr_en         <= 1'b0;
         log2_lut_data_out <= '0;
         exp2_lut_data_out <= '0;
         wr_count          <= '0;
         gap               <= '0;
      end else begin
         lut_wr_en <= hs;
         if (hs) begin
            log2_lut_data_out <= cfg_log2_data;
            exp2_lut_data_out <= cfg_exp2_data;
         end

         if (load_begin) begin
            wr_count <= '0;
            gap      <= '0;
         end else if (state == LOAD) begin
            if (hs) begin
               // hs cannot occur outside LOAD, and LOAD leaves once the count
               // hits LUT_SIZE, so wr_count cannot wrap.
               wr_count <= wr_count + CW'(1);
               gap      <= '0;
            end else begin
               gap <= gap + GW'(1);
            end
         end
      end
   end

`ifdef LUT_LOADER_CHECKSUM_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lut_checksum <= '0;
      end else if (load_begin) begin
         lut_checksum <= '0;
      end else if (hs) begin
         lut_checksum <= lut_checksum + 16'(cfg_log2_data) + 16'(cfg_exp2_data);
      end
   end
`endif

endmodule

// File: tb/tb_lut_stream_loader.sv
//------------------------------------------------------------------------------
// tb_lut_stream_loader
//
// Directed sequence with randomized data, checked against a beat-level
// reference model.  The model tracks the load phase, the accepted count, the
// idle gap, the expected write strobe and data, and the checksum.  Build with
// +define+LUT_LOADER_CHECKSUM_EN to include the checksum port and its checks.
//------------------------------------------------------------------------------
module tb_lut_stream_loader;

   localparam int LUT_SIZE    = 128;
   localparam int MANT_LEN    = 10;
   localparam int FLOAT_LEN   = 16;
   localparam int TIMEOUT_CYC = 1024;
   localparam int CW          = $clog2(LUT_SIZE) + 1;

   logic                 clk = 1'b0;
   logic                 rst_n;
   logic                 start;
   logic                 abort;
   logic                 cfg_valid;
   logic                 cfg_ready;
   logic [MANT_LEN-1:0]  cfg_log2_data;
   logic [FLOAT_LEN-1:0] cfg_exp2_data;
   logic                 lut_wr_en;
   logic [MANT_LEN-1:0]  log2_lut_data_out;
   logic [FLOAT_LEN-1:0] exp2_lut_data_out;
   logic [CW-1:0]        wr_count;
   logic                 lut_busy;
   logic                 lut_done;
   logic                 lut_err;
`ifdef LUT_LOADER_CHECKSUM_EN
   logic [15:0]          lut_checksum;
`endif

   lut_stream_loader #(
      .LUT_SIZE   (LUT_SIZE),
      .MANT_LEN   (MANT_LEN),
      .FLOAT_LEN  (FLOAT_LEN),
      .TIMEOUT_CYC(TIMEOUT_CYC)
   ) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .start            (start),
      .abort            (abort),
      .cfg_valid        (cfg_valid),
      .cfg_ready        (cfg_ready),
      .cfg_log2_data    (cfg_log2_data),
      .cfg_exp2_data    (cfg_exp2_data),
      .lut_wr_en        (lut_wr_en),
      .log2_lut_data_out(log2_lut_data_out),
      .exp2_lut_data_out(exp2_lut_data_out),
      .wr_count         (wr_count),
      .lut_busy         (lut_busy),
      .lut_done         (lut_done),
      .lut_err          (lut_err)
`ifdef LUT_LOADER_CHECKSUM_EN
      ,
      .lut_checksum     (lut_checksum)
`endif
   );

   always #5 clk = ~clk;

   // Count write strobes on the falling edge, away from the active edge.
   int pulses = 0;
   always @(negedge clk) if (lut_wr_en === 1'b1) pulses <= pulses + 1;

   int passed = 0;
   int total  = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   //---------------------------------------------------------------------------
   // Reference model (beat-level view of the loader)
   //---------------------------------------------------------------------------
   bit                   m_load, m_done, m_err;
   int                   m_cnt, m_gap;
   bit                   m_wen;
   logic [MANT_LEN-1:0]  m_l2;
   logic [FLOAT_LEN-1:0] m_e2;
   logic [15:0]          m_sum;

   task automatic model_reset();
      m_load = 0; m_done = 0; m_err = 0;
      m_cnt = 0; m_gap = 0; m_wen = 0;
      m_l2 = '0; m_e2 = '0; m_sum = '0;
   endtask

   task automatic model_edge(input bit st, input bit ab, input bit v,
                             input logic [MANT_LEN-1:0] l2, input logic [FLOAT_LEN-1:0] e2);
      bit accept;
      bit idle;
      accept = m_load && !ab && v;
      idle   = !m_load && !m_done && !m_err;
      m_wen  = accept;
      if (accept) begin m_l2 = l2; m_e2 = e2; end
      if (ab) begin
         m_load = 0; m_done = 0; m_err = 0;
      end else if (idle && st) begin
         m_load = 1; m_cnt = 0; m_gap = 0; m_sum = '0;
      end else if (m_load) begin
         if (accept) begin
            m_cnt++;
            m_gap = 0;
            m_sum = m_sum + 16'(l2) + e2;
            if (m_cnt == LUT_SIZE) begin m_load = 0; m_done = 1; end
         end else begin
            m_gap++;
            if (m_gap == TIMEOUT_CYC) begin m_load = 0; m_err = 1; end
         end
      end
   endtask

   task automatic check_outputs(input string ctx);
      check({ctx, ".lut_wr_en"}, lut_wr_en, m_wen);
      check({ctx, ".log2_out"}, log2_lut_data_out, m_l2);
      check({ctx, ".exp2_out"}, exp2_lut_data_out, m_e2);
      check({ctx, ".wr_count"}, wr_count, m_cnt);
      check({ctx, ".busy"}, lut_busy, m_load);
      check({ctx, ".done"}, lut_done, m_done);
      check({ctx, ".err"}, lut_err, m_err);
`ifdef LUT_LOADER_CHECKSUM_EN
      if (m_done) check({ctx, ".checksum"}, lut_checksum, m_sum);
`endif
   endtask

   // One clock cycle.  Inputs are driven just after the rising edge, ready is
   // checked mid-cycle, and outputs are checked just after the next edge.
   task automatic step(input string ctx, input bit st, input bit ab, input bit v,
                       input logic [MANT_LEN-1:0] l2, input logic [FLOAT_LEN-1:0] e2);
      start = st; abort = ab; cfg_valid = v; cfg_log2_data = l2; cfg_exp2_data = e2;
      #1;
      check({ctx, ".cfg_ready"}, cfg_ready, m_load && !ab);
      @(posedge clk);
      model_edge(st, ab, v, l2, e2);
      #1;
      check_outputs(ctx);
   endtask

   task automatic idle_step(input string ctx);
      step(ctx, 0, 0, 0, '0, '0);
   endtask

   task automatic rand_beat(input string ctx);
      step(ctx, 0, 0, 1, MANT_LEN'($urandom), FLOAT_LEN'($urandom));
   endtask

   //---------------------------------------------------------------------------
   // Directed sequence
   //---------------------------------------------------------------------------
   initial begin
      int base;
      int n;

      rst_n = 0; start = 0; abort = 0; cfg_valid = 0;
      cfg_log2_data = '0; cfg_exp2_data = '0;
      model_reset();
      #3;
      check_outputs("reset");
      check("reset.cfg_ready", cfg_ready, 1'b0);
      @(posedge clk); #1;
      rst_n = 1;
      idle_step("post_reset");

      // Full burst with log2=i, exp2=3C00+i.
      step("burst_start", 1, 0, 0, '0, '0);
      base = pulses;
      for (int i = 0; i < LUT_SIZE; i++)
         step("burst", 0, 0, 1, MANT_LEN'(i), FLOAT_LEN'(16'h3C00 + i));
      idle_step("burst_tail");
      check("burst.pulses", pulses - base, LUT_SIZE);
      check("burst.done", lut_done, 1'b1);
      check("burst.wr_count", wr_count, LUT_SIZE);
`ifdef LUT_LOADER_CHECKSUM_EN
      check("burst.checksum_const", lut_checksum, 16'h3F80);
`endif
      // A start seen in DONE is ignored.
      step("start_in_done", 1, 0, 0, '0, '0);
      check("start_in_done.wr_count", wr_count, LUT_SIZE);

      // Throttled load: a beat every 3rd cycle, with a start pulse mid-load.
      step("thr_abort", 0, 1, 0, '0, '0);
      step("thr_start", 1, 0, 0, '0, '0);
      base = pulses;
      for (int i = 0; i < LUT_SIZE; i++) begin
         rand_beat("thr");
         step("thr_gap", (i == 50), 0, 0, '0, '0);
         idle_step("thr_gap");
      end
      check("thr.pulses", pulses - base, LUT_SIZE);
      check("thr.done", lut_done, 1'b1);

      // Timeout: 5 beats, then silence.
      step("to_abort", 0, 1, 0, '0, '0);
      step("to_start", 1, 0, 0, '0, '0);
      base = pulses;
      for (int i = 0; i < 5; i++) rand_beat("to_beat");
      n = 0;
      while (lut_err !== 1'b1 && n < TIMEOUT_CYC + 100) begin
         idle_step("to_wait");
         n++;
      end
      check("to.cycles", n, TIMEOUT_CYC);
      check("to.wr_count", wr_count, 5);
      for (int i = 0; i < 10; i++) rand_beat("to_after");
      check("to.pulses", pulses - base, 5);
      check("to.err_sticky", lut_err, 1'b1);

      // Abort together with the 60th beat, then a full reload.
      step("ab_abort", 0, 1, 0, '0, '0);
      step("ab_start", 1, 0, 0, '0, '0);
      base = pulses;
      for (int i = 0; i < 59; i++) rand_beat("ab_beat");
      step("ab_beat60", 0, 1, 1, MANT_LEN'($urandom), FLOAT_LEN'($urandom));
      check("ab.idle", {lut_busy, lut_done, lut_err}, 3'b000);
      idle_step("ab_tail");
      check("ab.wr_count", wr_count, 59);
      check("ab.pulses", pulses - base, 59);
      // abort + start together in IDLE: abort wins.
      step("ab_both", 1, 1, 0, '0, '0);
      check("ab_both.busy", lut_busy, 1'b0);
      step("ab_reload", 1, 0, 0, '0, '0);
      base = pulses;
      for (int i = 0; i < LUT_SIZE; i++) rand_beat("ab_reload");
      idle_step("ab_reload_tail");
      check("ab_reload.pulses", pulses - base, LUT_SIZE);
      check("ab_reload.done", lut_done, 1'b1);

      // Async reset in the middle of beat 40.
      step("rs_abort", 0, 1, 0, '0, '0);
      step("rs_start", 1, 0, 0, '0, '0);
      for (int i = 0; i < 39; i++) rand_beat("rs_beat");
      start = 0; abort = 0; cfg_valid = 1;
      cfg_log2_data = MANT_LEN'($urandom); cfg_exp2_data = FLOAT_LEN'($urandom);
      #2;
      rst_n = 0;
      #1;
      model_reset();
      check_outputs("rs_now");
      check("rs_now.cfg_ready", cfg_ready, 1'b0);
      base = pulses;
      @(posedge clk); #1;
      check_outputs("rs_edge");
      cfg_valid = 0;
      rst_n = 1;
      idle_step("rs_release");
      check("rs.pulses", pulses - base, 0);
      step("rs_restart", 1, 0, 0, '0, '0);
      for (int i = 0; i < 3; i++) rand_beat("rs_recover");
      idle_step("rs_recover_tail");

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/lut_stream_loader.md
LUT_STREAM_LOADER -- requirements
Module: lut_stream_loader

Interface
REQ-001 Parameter LUT_SIZE, default 128: number of LUT entries per load.
REQ-002 Parameter MANT_LEN, default 10: log2 LUT entry width.
REQ-003 Parameter FLOAT_LEN, default 16: exp2 LUT entry width.
REQ-004 Parameter TIMEOUT_CYC, default 1024: maximum idle gap between accepted beats during a load, in cycles.
REQ-005 clk  input  1  clock; all state updates on the rising edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 start  input  1  single-cycle load request.
REQ-008 abort  input  1  cancel the load or clear the DONE/ERR state.
REQ-009 cfg_valid  input  1  host beat valid.
REQ-010 cfg_ready  output  1  loader accepts a beat.
REQ-011 cfg_log2_data  input  MANT_LEN  log2 entry from the host.
REQ-012 cfg_exp2_data  input  FLOAT_LEN  exp2 entry from the host.
REQ-013 lut_wr_en  output  1  write strobe to the LUT consumer; the consumer has no backpressure.
REQ-014 log2_lut_data_out  output  MANT_LEN  log2 write data.
REQ-015 exp2_lut_data_out  output  FLOAT_LEN  exp2 write data.
REQ-016 wr_count  output  $clog2(LUT_SIZE)+1  number of entries accepted in the current load.
REQ-017 lut_busy / lut_done / lut_err  output  1 each  high in LOAD / DONE / ERR respectively.

Function
REQ-018 The FSM SHALL have exactly four states: IDLE, LOAD, DONE and ERR.
REQ-019 IDLE with start=1 SHALL move to LOAD on the next cycle and clear wr_count; in all other states, start SHALL be ignored.
REQ-020 cfg_ready SHALL equal (state==LOAD) && !abort, driven combinationally.
REQ-021 A handshake occurs when cfg_valid && cfg_ready; on a handshake, wr_count increments by 1 and the gap counter clears.
REQ-022 Each handshake SHALL produce exactly one lut_wr_en pulse one cycle later, with log2_lut_data_out and exp2_lut_data_out registered from the accepted beat; latency SHALL be 1 cycle.
REQ-023 When lut_wr_en=0, the data outputs SHALL hold their last value.
REQ-024 A handshake that brings wr_count to LUT_SIZE SHALL cause LOAD->DONE on the same edge, so that back-to-back beats fill the LUT in exactly LUT_SIZE cycles.
REQ-025 Over a complete load, exactly LUT_SIZE lut_wr_en pulses SHALL be issued, with the final pulse in the first DONE cycle.
REQ-026 In LOAD, each cycle without a handshake SHALL increment the gap counter; when it reaches TIMEOUT_CYC, the FSM moves LOAD->ERR, cfg_ready drops and wr_count holds.
REQ-027 abort=1 in any state SHALL move the FSM to IDLE on the next edge.
REQ-028 An abort coincident with cfg_valid SHALL produce no handshake and no later lut_wr_en.
REQ-029 A lut_wr_en pulse already registered before the abort SHALL still be issued.
REQ-030 abort and start asserted together in IDLE: abort wins and the FSM stays in IDLE.
REQ-031 DONE and ERR SHALL be sticky until abort or reset.
REQ-032 wr_count SHALL never exceed LUT_SIZE; no wrap-around is permitted.

Reset
REQ-033 rst_n low SHALL asynchronously force: state=IDLE, wr_count=0, gap counter=0, lut_wr_en=0, both data outputs=0, cfg_ready=0, lut_busy=0, lut_done=0, lut_err=0.
REQ-034 Reset asserted mid-load SHALL discard any pending beat and issue no further lut_wr_en.

Configuration
REQ-035 Macro LUT_LOADER_CHECKSUM_EN SHALL be the only compile-time option.
REQ-036 With LUT_LOADER_CHECKSUM_EN defined, output lut_checksum[15:0] SHALL exist and behave as follows:
- cleared on start;
- on each handshake, adds zero-extended cfg_log2_data plus cfg_exp2_data, modulo 2^16;
- valid and stable while lut_done=1.
REQ-037 Without LUT_LOADER_CHECKSUM_EN, the lut_checksum port and its logic SHALL be absent; all other behaviour is identical.

Verification
REQ-038 Full burst: reset, start, 128 back-to-back beats with log2=i, exp2=16'h3C00+i.
- Required response: lut_wr_en high for 128 consecutive cycles, starting 1 cycle after the first handshake.
- lut_done=1 and wr_count=128.
- With LUT_LOADER_CHECKSUM_EN: checksum=16'h3F80.
REQ-039 Throttled: cfg_valid high every 3rd cycle -> exactly 128 pulses, each 1 cycle after its handshake; data order preserved.
REQ-040 Timeout: 5 beats then cfg_valid held low -> lut_err=1 exactly 1024 cycles after the 5th handshake; wr_count=5; no further lut_wr_en.
REQ-041 Abort mid-load: abort together with the 60th beat -> wr_count stays 59; exactly 59 pulses issued; IDLE next cycle; a new start reloads all 128 entries.
REQ-042 Async reset asserted in the middle of beat 40 -> all outputs 0 immediately, with no pulse on the following clock edge.
REQ-043 start pulsed in LOAD and in DONE -> ignored, with no change to wr_count or state.
